draw_scheduler: RTL and testbench

Sequencer and arbiter for the shared parallel LCD draw engine in the dino game top level. Accepts redraw requests from the dino-jump and cactus-move blocks, plus a full-screen redraw triggered by game-state changes, and grants the engine to one requester at a time. Snapshots sprite coordinates at grant time so they stay stable while the engine draws. Returns one-cycle completion pulses that drive the requesters' `drawDone*` inputs.

---
 rtl/draw_scheduler.sv | 157 +++++++++++++++
 tb/tb_draw_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// draw_scheduler
//   Arbitrates the shared LCD draw engine between the dino sprite, the cactus
//   sprite and a full-screen redraw raised by game-state changes. Sprite
//   coordinates are snapshotted at grant so they stay stable while the engine
//   draws. One-cycle done pulses feed back to the requesters.
//
//   Optional feature: define DRAW_WATCHDOG_EN to enable a WAIT-state watchdog
//   that forces completion after TIMEOUT cycles and sets sticky timeout_flag.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   state[2:0]        game state (0 IDLE, 1 RUN, 2 OVER, 3 WIN)
//   dino_req          dino redraw request (level, held until done_dino)
//   cactus_req        cactus redraw request (level, held until done_cactus)
//   dino_y, cactus_x  live sprite coordinates
//   eng_done          engine completion pulse
//   eng_start         one-cycle engine start
//   eng_sel[1:0]      job select: 0 none, 1 dino, 2 cactus, 3 full screen
//   dino_y_q, cactus_x_q  coordinate snapshots taken at grant
//   done_dino, done_cactus  one-cycle completion pulses
//   busy              high while a job is in flight (ISSUE/WAIT/ACK)
//   timeout_flag      sticky watchdog flag (0 when watchdog not built)
module draw_scheduler #(
   parameter int                   TIMEOUT_W = 16,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] state,
   input  logic       dino_req,
   input  logic       cactus_req,
   input  logic [7:0] dino_y,
   input  logic [8:0] cactus_x,
   input  logic       eng_done,
   output logic       eng_start,
   output logic [1:0] eng_sel,
   output logic [7:0] dino_y_q,
   output logic [8:0] cactus_x_q,
   output logic       done_dino,
   output logic       done_cactus,
   output logic       busy,
   output logic       timeout_flag
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   localparam logic [1:0] SEL_NONE   = 2'd0;
   localparam logic [1:0] SEL_DINO   = 2'd1;
   localparam logic [1:0] SEL_CACTUS = 2'd2;
   localparam logic [1:0] SEL_SCR    = 2'd3;

   localparam logic RR_DINO   = 1'b0;
   localparam logic RR_CACTUS = 1'b1;

   logic [1:0] fsm;
   logic [2:0] state_q;
   logic       scr_pend;
   logic       rr_last;
   logic       wd_expire;
   logic       drop_mode;
   logic [1:0] sprite_pick;

   // Game over / win: sprites are no longer drawn, but requesters must still
   // see a done pulse so they do not stall.
   assign drop_mode = (state == 3'd2) || (state == 3'd3);

   // Tie between sprites goes to whichever was not served last.
   assign sprite_pick = (dino_req && (!cactus_req || rr_last == RR_CACTUS))
                        ? SEL_DINO : SEL_CACTUS;

   assign eng_start   = (fsm == S_ISSUE);
   assign busy        = (fsm != S_IDLE);
   assign done_dino   = (fsm == S_ACK) && (eng_sel == SEL_DINO);
   assign done_cactus = (fsm == S_ACK) && (eng_sel == SEL_CACTUS);

`ifdef DRAW_WATCHDOG_EN
   localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT - 1'b1;

   logic [TIMEOUT_W-1:0] wd_cnt;
   logic                 wd_flag;

   assign wd_expire    = (fsm == S_WAIT) && (wd_cnt == WD_LAST);
   assign timeout_flag = wd_flag;

   // Counter is cleared in ISSUE so it starts from 0 on entry to WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt  <= '0;
         wd_flag <= 1'b0;
      end else begin
         if (fsm == S_ISSUE)
            wd_cnt <= '0;
         else if (fsm == S_WAIT)
            wd_cnt <= wd_cnt + 1'b1;
         // A real completion on the expiry cycle wins; no flag then.
         if (wd_expire && !eng_done)
            wd_flag <= 1'b1;
      end
   end
`else
   assign wd_expire    = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm        <= S_IDLE;
         state_q    <= 3'd0;
         scr_pend   <= 1'b0;
         rr_last    <= RR_CACTUS;
         eng_sel    <= SEL_NONE;
         dino_y_q   <= 8'd0;
         cactus_x_q <= 9'd0;
      end else begin
         state_q <= state;
         // A new state change re-arms the pending flag even while a
         // full-screen job is being acknowledged.
         if (state != state_q)
            scr_pend <= 1'b1;
         else if (fsm == S_ACK && eng_sel == SEL_SCR)
            scr_pend <= 1'b0;

         case (fsm)
            S_IDLE: begin
               if (scr_pend) begin
                  eng_sel    <= SEL_SCR;
                  dino_y_q   <= dino_y;
                  cactus_x_q <= cactus_x;
                  fsm        <= S_ISSUE;
               end else if (dino_req || cactus_req) begin
                  eng_sel    <= sprite_pick;
                  dino_y_q   <= dino_y;
                  cactus_x_q <= cactus_x;
                  fsm        <= drop_mode ? S_ACK : S_ISSUE;
               end
            end
            S_ISSUE: fsm <= S_WAIT;
            S_WAIT: begin
               if (eng_done || wd_expire)
                  fsm <= S_ACK;
            end
            default: begin
               if (eng_sel == SEL_DINO)
                  rr_last <= RR_DINO;
               else if (eng_sel == SEL_CACTUS)
                  rr_last <= RR_CACTUS;
               eng_sel <= SEL_NONE;
               fsm     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: reset, round-robin, single job timing,
// state change mid-job, drop mode, watchdog (or its absence), reset mid-WAIT.
module tb_draw_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state;
   logic       dino_req, cactus_req;
   logic [7:0] dino_y;
   logic [8:0] cactus_x;
   logic       eng_done;
   logic       eng_start;
   logic [1:0] eng_sel;
   logic [7:0] dino_y_q;
   logic [8:0] cactus_x_q;
   logic       done_dino, done_cactus, busy, timeout_flag;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   draw_scheduler #(.TIMEOUT_W(16), .TIMEOUT(16'd16)) dut (
      .clk(clk), .rst(rst), .state(state),
      .dino_req(dino_req), .cactus_req(cactus_req),
      .dino_y(dino_y), .cactus_x(cactus_x), .eng_done(eng_done),
      .eng_start(eng_start), .eng_sel(eng_sel),
      .dino_y_q(dino_y_q), .cactus_x_q(cactus_x_q),
      .done_dino(done_dino), .done_cactus(done_cactus),
      .busy(busy), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called with the next edge being the grant edge; returns in the idle
   // cycle after ACK. eng_done is pulsed in ISSUE to show it is ignored.
   task automatic do_job(input logic [1:0] sel, input logic [7:0] y, input logic [8:0] x);
      tick();
      check("job_start", 32'(eng_start), 1);
      check("job_sel", 32'(eng_sel), 32'(sel));
      check("job_snap_y", 32'(dino_y_q), 32'(y));
      check("job_snap_x", 32'(cactus_x_q), 32'(x));
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("job_wait_start", 32'(eng_start), 0);
      tick();
      check("job_issue_done_ignored", 32'({busy, done_dino, done_cactus}), 32'b100);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("job_ack_sel", 32'(eng_sel), 32'(sel));
      check("job_done_dino", 32'(done_dino), 32'(sel == 2'd1));
      check("job_done_cactus", 32'(done_cactus), 32'(sel == 2'd2));
      tick();
      check("job_idle", 32'({busy, eng_sel, done_dino, done_cactus}), 0);
   endtask

   initial begin
      rst = 1'b0; state = 3'd0; dino_req = 1'b0; cactus_req = 1'b0;
      dino_y = 8'd0; cactus_x = 9'd0; eng_done = 1'b0;
      #2;
      check("rst_start", 32'(eng_start), 0);
      check("rst_sel", 32'(eng_sel), 0);
      check("rst_snap", 32'({dino_y_q, cactus_x_q}), 0);
      check("rst_misc", 32'({done_dino, done_cactus, busy, timeout_flag}), 0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // Round-robin with both held: dino wins the first tie
      dino_req = 1'b1; cactus_req = 1'b1; dino_y = 8'd11; cactus_x = 9'd300;
      do_job(2'd1, 8'd11, 9'd300);
      do_job(2'd2, 8'd11, 9'd300);
      do_job(2'd1, 8'd11, 9'd300);
      do_job(2'd2, 8'd11, 9'd300);
      dino_req = 1'b0; cactus_req = 1'b0;
      tick();

      // Single dino job, eng_done late; snapshot holds while live Y moves
      dino_req = 1'b1; dino_y = 8'd90; cactus_x = 9'd5;
      tick();
      check("single_start", 32'(eng_start), 1);
      check("single_sel", 32'(eng_sel), 1);
      check("single_snap_y", 32'(dino_y_q), 90);
      check("single_snap_x", 32'(cactus_x_q), 5);
      dino_y = 8'd60; cactus_x = 9'd7;
      tick();
      check("single_start_drop", 32'(eng_start), 0);
      check("single_hold_y", 32'(dino_y_q), 90);
      tick(); tick(); tick();
      check("single_wait", 32'({busy, done_dino}), 32'b10);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("single_done", 32'(done_dino), 1);
      check("single_ack_y", 32'(dino_y_q), 90);
      dino_req = 1'b0;
      tick();
      check("single_idle", 32'({busy, eng_sel, done_dino}), 0);
      check("single_keep_y", 32'(dino_y_q), 90);

      // State change while a cactus job waits
      cactus_x = 9'd123; cactus_req = 1'b1;
      tick();
      check("chg_sel", 32'(eng_sel), 2);
      check("chg_snap_x", 32'(cactus_x_q), 123);
      tick();
      state = 3'd1; dino_req = 1'b1;
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("chg_cactus_done", 32'({done_cactus, eng_sel}), 32'b110);
      cactus_req = 1'b0;
      tick();
      check("chg_idle", 32'(busy), 0);
      tick();
      check("chg_scr_sel", 32'({eng_start, eng_sel}), 32'b111);
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("chg_scr_ack", 32'({eng_sel, done_dino, done_cactus}), 32'b1100);
      tick();
      do_job(2'd1, 8'd60, 9'd123);
      dino_req = 1'b0;

      // Drop mode: OVER, full screen served first, then sprites bypass engine
      state = 3'd2;
      tick();
      do_job(2'd3, 8'd60, 9'd123);
      cactus_req = 1'b1;
      tick();
      check("drop_cactus_done", 32'({done_cactus, eng_start, busy, eng_sel}), 32'b10110);
      cactus_req = 1'b0;
      tick();
      check("drop_cactus_idle", 32'({done_cactus, eng_start, busy}), 0);
      dino_req = 1'b1;
      tick();
      check("drop_dino_done", 32'({done_dino, eng_start}), 32'b10);
      dino_req = 1'b0;
      tick();
      check("drop_dino_idle", 32'({done_dino, busy}), 0);

      // Back to RUN, then a job whose engine never answers
      state = 3'd1;
      tick();
      do_job(2'd3, 8'd60, 9'd123);
      dino_req = 1'b1;
`ifdef DRAW_WATCHDOG_EN
      tick();
      check("wd_start", 32'(eng_start), 1);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("wd_waiting", 32'({busy, done_dino, timeout_flag}), 32'b100);
      end
      tick();
      check("wd_expire", 32'({done_dino, timeout_flag}), 32'b11);
      dino_req = 1'b0;
      tick();
      check("wd_sticky", 32'({timeout_flag, busy}), 32'b10);
      dino_req = 1'b1;
      tick(); tick();
`else
      tick();
      check("nowd_start", 32'(eng_start), 1);
      repeat (40) tick();
      check("nowd_busy", 32'({busy, eng_sel, timeout_flag, done_dino}), 32'b10100);
`endif

      // Reset mid-WAIT with dino selected
      check("pre_rst_sel", 32'(eng_sel), 1);
      rst = 1'b0;
      #1;
      check("arst_sel_busy", 32'({eng_sel, busy, eng_start}), 0);
      check("arst_snap", 32'({dino_y_q, cactus_x_q}), 0);
      check("arst_flags", 32'({done_dino, done_cactus, timeout_flag}), 0);
      state = 3'd0; cactus_req = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_dino_first", 32'({eng_start, eng_sel}), 32'b101);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
